unidade_busca: RTL and testbench
================================

Name: unidade_busca

Overview:
Instruction-fetch sequencer for the TI170 8-bit core. It drives the address of the combinational program ROM (memoria_programa, 128 x 8) and assembles 1- or 2-byte instructions (opcode + operand). Instructions go to decode/execute over a valid/ready handshake. It resolves unconditional BRA internally, accepts redirects from execute, and halts on WAI or on an out-of-range fetch.

Parameters:
LARGURA_END, 8, width of the program counter and of the ROM address.
TAM_ROM, 128, number of valid ROM locations; addresses >= TAM_ROM are illegal.
BRA_INTERNO, 1, 1 = BRA is consumed by the fetch unit and never delivered downstream.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
endereco  out  LARGURA_END  ROM address; equals pc.
dado  in  8  ROM read data, combinational from endereco, same cycle.
instr_valido  out  1  instruction outputs hold a valid instruction.
instr_pronto  in  1  consumer accepts; transfer when instr_valido && instr_pronto.
opcode  out  8  delivered opcode.
operando  out  8  delivered operand; 0x00 for 1-byte instructions.
instr_pc  out  LARGURA_END  address of the delivered opcode.
instr_tamanho  out  1  0 = 1 byte, 1 = 2 bytes.
desvio_valido  in  1  redirect request from execute (taken branch/jump).
desvio_endereco  in  LARGURA_END  redirect target.
parado  out  1  fetch unit is in state PARADO.
erro_endereco  out  1  sticky flag: fetch attempted at pc >= TAM_ROM.

Behaviour:
- Async reset (rst_n=0): pc=0, state BUSCA_OP. All outputs are 0, including instr_valido, opcode, operando, instr_pc, instr_tamanho, parado and erro_endereco.
- Instruction length: opcode[7]=1 or opcode[7:4]=0x2 -> 2 bytes; all other opcodes -> 1 byte.
- State BUSCA_OP:
  - If pc >= TAM_ROM: set erro_endereco, go to PARADO.
  - Otherwise: opcode<=dado, instr_pc<=pc, pc<=pc+1.
  - 1-byte opcode: operando<=0, go to ENTREGA. 2-byte opcode: go to BUSCA_OPER.
- State BUSCA_OPER:
  - If pc >= TAM_ROM: set erro_endereco, go to PARADO; the partial instruction is discarded.
  - Otherwise: operando<=dado, pc<=pc+1.
  - If opcode=0x20 and BRA_INTERNO=1: pc<=dado (absolute target), go to BUSCA_OP.
  - Otherwise go to ENTREGA.
- State ENTREGA: instr_valido=1. All instruction outputs and pc hold stable while instr_pronto=0.
  - On transfer with opcode=0x3E (WAI): go to PARADO.
  - On transfer with any other opcode: go to BUSCA_OP.
- State PARADO: instr_valido=0, parado=1, pc frozen. Only desvio_valido or reset leaves this state.
- Latency after reset release (cycle 0 = first BUSCA_OP):
  - 1-byte instruction: instr_valido high in cycle 1.
  - 2-byte instruction: instr_valido high in cycle 2.
  - Internal BRA: 2 cycles, no delivery.
- desvio_valido (any state) has highest priority:
  - pc<=desvio_endereco, state<=BUSCA_OP, instr_valido=0 from the next cycle.
  - Any partially fetched instruction is discarded.
  - If a transfer occurs in the same cycle, the transfer counts as completed.
  - In PARADO it also clears erro_endereco.
- pc arithmetic is LARGURA_END bits, modulo 2^LARGURA_END. Range checking catches overflow before any wrap can matter.
- endereco is registered pc, with no combinational path from inputs.

Decomposition:
- Package pkg_processador holds:
  - opcode constants OPC_BRA=8'h20, OPC_WAI=8'h3E, OPC_LDA_IMM=8'h86, OPC_STA_DIR=8'h96;
  - the state encoding BUSCA_OP/BUSCA_OPER/ENTREGA/PARADO;
  - function tamanho_instr(opcode).
- No sub-module. The ROM is instantiated beside this block at top level.

Test Plan:
1. ROM 0:86 AA 96 E0 20 00, instr_pronto=1 constantly -> deliveries in a repeating loop:
   - (86,AA,pc 00) at cycle 2;
   - (96,E0,pc 02) at cycle 5;
   - BRA never visible; (86,AA,pc 00) again at cycle 10.
2. Same program, instr_pronto=0 for 5 cycles during (86,AA) -> opcode, operando, instr_pc and endereco=02 stable throughout; the next delivery follows release by 3 cycles.
3. desvio_valido=1, desvio_endereco=02 during BUSCA_OPER of 86 -> 86 never delivered; next delivery is (96,E0,instr_pc 02).
4. ROM[10]=3E, desvio to 0x10 -> (3E, operando 00, tamanho 0) delivered; after acceptance parado=1 and endereco frozen. Then desvio to 00 -> (86,AA) delivered 2 cycles later.
5. ROM[7F]=86, desvio to 7F -> erro_endereco=1 and parado=1 two cycles later; no instruction delivered. Desvio to 00 clears both.
6. rst_n pulsed low while instr_valido=1 -> all outputs 0 immediately, without a clock edge. After release, fetch restarts at endereco 00.

Source files
------------

// File: rtl/pkg_processador.sv
// Shared definitions for the TI170 core: opcodes, fetch state encoding and
// the instruction-length rule.
package pkg_processador;

    localparam logic [7:0] OPC_BRA     = 8'h20;
    localparam logic [7:0] OPC_WAI     = 8'h3E;
    localparam logic [7:0] OPC_LDA_IMM = 8'h86;
    localparam logic [7:0] OPC_STA_DIR = 8'h96;

    typedef enum logic [1:0] {
        BUSCA_OP   = 2'd0,
        BUSCA_OPER = 2'd1,
        ENTREGA    = 2'd2,
        PARADO     = 2'd3
    } estado_t;

    // 1 = opcode is followed by an operand byte.
    function automatic logic tamanho_instr(input logic [7:0] op);
        return op[7] || (op[7:4] == 4'h2);
    endfunction

endpackage

// File: rtl/unidade_busca.sv
// Instruction-fetch sequencer: walks the program ROM, assembles 1/2-byte
// instructions and hands them to execute over a valid/ready handshake.
module unidade_busca
    import pkg_processador::*;
#(
    parameter int LARGURA_END = 8,
    parameter int TAM_ROM     = 128,
    parameter int BRA_INTERNO = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [LARGURA_END-1:0] endereco,
    input  logic [7:0]             dado,
    output logic                   instr_valido,
    input  logic                   instr_pronto,
    output logic [7:0]             opcode,
    output logic [7:0]             operando,
    output logic [LARGURA_END-1:0] instr_pc,
    output logic                   instr_tamanho,
    input  logic                   desvio_valido,
    input  logic [LARGURA_END-1:0] desvio_endereco,
    output logic                   parado,
    output logic                   erro_endereco
);

    // Extra bit keeps the limit exact even when TAM_ROM == 2**LARGURA_END.
    localparam logic [LARGURA_END:0] LIMITE = (LARGURA_END + 1)'(TAM_ROM);

    estado_t                state_q, state_d;
    logic [LARGURA_END-1:0] pc_q, pc_d;
    logic [LARGURA_END-1:0] instr_pc_q, instr_pc_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [7:0]             operando_q, operando_d;
    logic                   tamanho_q, tamanho_d;
    logic                   erro_q, erro_d;

    logic fora_rom;
    logic transferencia;

    assign fora_rom      = {1'b0, pc_q} >= LIMITE;
    assign transferencia = (state_q == ENTREGA) && instr_pronto;

    always_comb begin
        // NOTE: every target gets its hold value first so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        opcode_d   = opcode_q;
        operando_d = operando_q;
        tamanho_d  = tamanho_q;
        erro_d     = erro_q;

        unique case (state_q)
            BUSCA_OP: begin
                if (fora_rom) begin
                    erro_d  = 1'b1;
                    state_d = PARADO;
                end else begin
                    opcode_d   = dado;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + LARGURA_END'(1);
                    tamanho_d  = tamanho_instr(dado);
                    if (tamanho_instr(dado)) begin
                        state_d = BUSCA_OPER;
                    end else begin
                        operando_d = 8'h00;
                        state_d    = ENTREGA;
                    end
                end
            end
            BUSCA_OPER: begin
                if (fora_rom) begin
                    erro_d  = 1'b1;
                    state_d = PARADO;
                end else begin
                    operando_d = dado;
                    pc_d       = pc_q + LARGURA_END'(1);
                    if ((BRA_INTERNO != 0) && (opcode_q == OPC_BRA)) begin
                        pc_d    = LARGURA_END'(dado);
                        state_d = BUSCA_OP;
                    end else begin
                        state_d = ENTREGA;
                    end
                end
            end
            ENTREGA: begin
                if (transferencia) begin
                    state_d = (opcode_q == OPC_WAI) ? PARADO : BUSCA_OP;
                end
            end
            PARADO: begin
            end
            default: state_d = BUSCA_OP;
        endcase

        // Redirects win over everything, including a same-cycle transfer.
        if (desvio_valido) begin
            pc_d    = desvio_endereco;
            state_d = BUSCA_OP;
            if (state_q == PARADO) begin
                erro_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUSCA_OP;
            pc_q       <= '0;
            instr_pc_q <= '0;
            opcode_q   <= 8'h00;
            operando_q <= 8'h00;
            tamanho_q  <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            opcode_q   <= opcode_d;
            operando_q <= operando_d;
            tamanho_q  <= tamanho_d;
            erro_q     <= erro_d;
        end
    end

    assign endereco      = pc_q;
    assign instr_valido  = (state_q == ENTREGA);
    assign parado        = (state_q == PARADO);
    assign opcode        = opcode_q;
    assign operando      = operando_q;
    assign instr_pc      = instr_pc_q;
    assign instr_tamanho = tamanho_q;
    assign erro_endereco = erro_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca with a behavioural combinational ROM.
module tb_unidade_busca;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] endereco;
    logic [7:0] dado;
    logic       instr_valido;
    logic       instr_pronto;
    logic [7:0] opcode;
    logic [7:0] operando;
    logic [7:0] instr_pc;
    logic       instr_tamanho;
    logic       desvio_valido;
    logic [7:0] desvio_endereco;
    logic       parado;
    logic       erro_endereco;

    logic [7:0] rom [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign dado = rom[endereco];

    unidade_busca dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .endereco       (endereco),
        .dado           (dado),
        .instr_valido   (instr_valido),
        .instr_pronto   (instr_pronto),
        .opcode         (opcode),
        .operando       (operando),
        .instr_pc       (instr_pc),
        .instr_tamanho  (instr_tamanho),
        .desvio_valido  (desvio_valido),
        .desvio_endereco(desvio_endereco),
        .parado         (parado),
        .erro_endereco  (erro_endereco)
    );

    typedef struct {
        logic       rst;
        logic       pronto;
        logic       desvio;
        logic [7:0] dend;
        logic       v;
        logic [7:0] ender;
        logic [7:0] op;
        logic [7:0] oper;
        logic [7:0] ipc;
        logic       tam;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instr_pronto    = 1'b0;
        desvio_valido   = 1'b0;
        desvio_endereco = 8'h00;
        rst_n           = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!instr_valido && n < max_cycles) begin
            step();
            n++;
        end
        check("wait_valid_timeout", instr_valido, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h01;
        rom[8'h00] = 8'h86; rom[8'h01] = 8'hAA;
        rom[8'h02] = 8'h96; rom[8'h03] = 8'hE0;
        rom[8'h04] = 8'h20; rom[8'h05] = 8'h00;
        rom[8'h10] = 8'h3E;
        rom[8'h7F] = 8'h86;

        //          rst  rdy  dsv  dend   v    end    op     oper   ipc    tam
        // Free-running loop 86 AA / 96 E0 / BRA 00.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h86, 8'hAA, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h96, 8'hE0, 8'h02, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h86, 8'hAA, 8'h00, 1'b1};
        // Redirect to 02 while fetching the operand of 86.
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h96, 8'hE0, 8'h02, 1'b1};

        // Reset values, asserted asynchronously before any clock edge.
        instr_pronto    = 1'b0;
        desvio_valido   = 1'b0;
        desvio_endereco = 8'h00;
        rst_n           = 1'b0;
        #2;
        check("rst_valido",   instr_valido, 0);
        check("rst_endereco", endereco, 0);
        check("rst_parado",   parado, 0);
        check("rst_erro",     erro_endereco, 0);
        check("rst_opcode",   opcode, 0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) do_reset();
            instr_pronto    = vecs[i].pronto;
            desvio_valido   = vecs[i].desvio;
            desvio_endereco = vecs[i].dend;
            check($sformatf("v%0d_valido", i), instr_valido, vecs[i].v);
            check($sformatf("v%0d_endereco", i), endereco, vecs[i].ender);
            if (vecs[i].v) begin
                check($sformatf("v%0d_opcode", i), opcode, vecs[i].op);
                check($sformatf("v%0d_operando", i), operando, vecs[i].oper);
                check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].ipc);
                check($sformatf("v%0d_tamanho", i), instr_tamanho, vecs[i].tam);
            end
            step();
        end

        // Back-pressure: outputs hold while instr_pronto is low.
        do_reset();
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check("stall_valido",   instr_valido, 1);
            check("stall_opcode",   opcode, 8'h86);
            check("stall_operando", operando, 8'hAA);
            check("stall_instr_pc", instr_pc, 8'h00);
            check("stall_endereco", endereco, 8'h02);
            step();
        end
        instr_pronto = 1'b1;
        step();
        instr_pronto = 1'b0;
        check("rel1_valido", instr_valido, 0);
        step();
        check("rel2_valido", instr_valido, 0);
        step();
        check("rel3_valido", instr_valido, 1);
        check("rel3_opcode", opcode, 8'h96);
        check("rel3_ipc",    instr_pc, 8'h02);

        // WAI at 0x10 halts; a redirect resumes.
        desvio_valido = 1'b1; desvio_endereco = 8'h10;
        step();
        desvio_valido = 1'b0;
        check("wai_busca_valido", instr_valido, 0);
        check("wai_busca_end",    endereco, 8'h10);
        instr_pronto = 1'b1;
        step();
        check("wai_valido",   instr_valido, 1);
        check("wai_opcode",   opcode, 8'h3E);
        check("wai_operando", operando, 8'h00);
        check("wai_tamanho",  instr_tamanho, 0);
        check("wai_ipc",      instr_pc, 8'h10);
        step();
        for (int i = 0; i < 3; i++) begin
            check("wai_parado",   parado, 1);
            check("wai_pvalido",  instr_valido, 0);
            check("wai_endereco", endereco, 8'h11);
            step();
        end
        desvio_valido = 1'b1; desvio_endereco = 8'h00;
        step();
        desvio_valido = 1'b0;
        check("resume_parado", parado, 0);
        check("resume_end",    endereco, 8'h00);
        step();
        step();
        check("resume_valido",   instr_valido, 1);
        check("resume_opcode",   opcode, 8'h86);
        check("resume_operando", operando, 8'hAA);

        // Operand fetch at 0x80 runs off the ROM.
        desvio_valido = 1'b1; desvio_endereco = 8'h7F;
        step();
        desvio_valido = 1'b0;
        check("oob0_valido", instr_valido, 0);
        check("oob0_end",    endereco, 8'h7F);
        step();
        check("oob1_valido", instr_valido, 0);
        check("oob1_erro",   erro_endereco, 0);
        step();
        check("oob2_erro",   erro_endereco, 1);
        check("oob2_parado", parado, 1);
        check("oob2_valido", instr_valido, 0);
        step();
        check("oob3_erro",   erro_endereco, 1);
        check("oob3_end",    endereco, 8'h80);
        desvio_valido = 1'b1; desvio_endereco = 8'h00;
        step();
        desvio_valido = 1'b0;
        check("oobclr_erro",   erro_endereco, 0);
        check("oobclr_parado", parado, 0);
        check("oobclr_end",    endereco, 8'h00);

        // Asynchronous reset while an instruction is on offer.
        instr_pronto = 1'b0;
        wait_valid(10);
        rst_n = 1'b0;
        #1;
        check("arst_valido",   instr_valido, 0);
        check("arst_opcode",   opcode, 0);
        check("arst_operando", operando, 0);
        check("arst_ipc",      instr_pc, 0);
        check("arst_tamanho",  instr_tamanho, 0);
        check("arst_endereco", endereco, 0);
        check("arst_parado",   parado, 0);
        check("arst_erro",     erro_endereco, 0);
        step();
        rst_n = 1'b1;
        check("arst_rel_end", endereco, 8'h00);
        step();
        step();
        check("arst_rel_valido", instr_valido, 1);
        check("arst_rel_opcode", opcode, 8'h86);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
